// File: rtl/fc_classify.sv
// fc_classify: fully-connected output stage. On start it streams the flattened
// layer (csel=3'b101) against a weight memory and computes N_OUT dot products.
// Each dot product gets a bias, round-half-up, saturation to signed Q4.16 and an
// optional ReLU. The result is then written to csel=3'b110 at address j. The
// index of the largest result (lowest index on ties) is reported on class_id.
//
// Ports
//   clk       clock, all state on the rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle request, honoured only while busy=0
//   busy      high from the cycle after an accepted start until the done pulse
//   done      one-cycle pulse after the last result write
//   crd       flatten-memory read strobe
//   caddr_rd  flatten-memory read address (input index i)
//   cdata_rd  flatten data, one cycle after the registered read request
//   csel      3'b101 while reading, 3'b110 while writing, held when idle
//   cwr       result write strobe
//   caddr_wr  result address (neuron index j)
//   cdata_wr  result word
//   wrd       weight read strobe
//   waddr     weight address: j*N_IN+i for weights, N_OUT*N_IN+j for bias
//   wdata     weight/bias word, same latency as cdata_rd
//   class_id  argmax neuron index, held until the next start
module fc_classify #(
    parameter int N_IN    = 2048,
    parameter int N_OUT   = 10,
    parameter int WADDR_W = 15,
    parameter int RELU    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               crd,
    output logic [11:0]        caddr_rd,
    input  logic [19:0]        cdata_rd,
    output logic [2:0]         csel,
    output logic               cwr,
    output logic [11:0]        caddr_wr,
    output logic [19:0]        cdata_wr,
    output logic               wrd,
    output logic [WADDR_W-1:0] waddr,
    input  logic [19:0]        wdata,
    output logic [3:0]         class_id
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_TAIL  = 3'd2;
    localparam logic [2:0] S_BIAS  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0]         CSEL_RD   = 3'b101;
    localparam logic [2:0]         CSEL_WR   = 3'b110;
    localparam logic [WADDR_W-1:0] BIAS_BASE = WADDR_W'(N_OUT * N_IN);
    localparam logic [WADDR_W-1:0] ROW_STEP  = WADDR_W'(N_IN);
    localparam logic [11:0]        I_LAST    = 12'(N_IN - 1);
    localparam logic [3:0]         J_LAST    = 4'(N_OUT - 1);

    logic [2:0]         state;
    logic [3:0]         j_cnt;
    logic [47:0]        acc;
    logic [19:0]        best;
    logic [WADDR_W-1:0] w_base;
    // A read issued last cycle means operands are present on cdata_rd/wdata now.
    logic               pend;

    logic signed [39:0] prod;
    logic signed [32:0] rnd;
    logic signed [33:0] s_wide;
    logic [19:0]        s_res;

    // Rounding and bias use the full accumulator so large sums saturate
    // instead of wrapping through a narrow field.
    always_comb begin
        prod   = $signed(cdata_rd) * $signed(wdata);
        rnd    = $signed({acc[47], acc[47:16]}) + $signed({32'b0, acc[15]});
        s_wide = $signed({rnd[32], rnd}) + $signed({{14{wdata[19]}}, wdata});
        if (s_wide > 34'sd524287) begin
            s_res = 20'h7FFFF;
        end else if (s_wide < -34'sd524288) begin
            s_res = 20'h80000;
        end else begin
            s_res = s_wide[19:0];
        end
        if ((RELU != 0) && (s_wide < 0)) begin
            s_res = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            wrd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= '0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            waddr    <= '0;
            class_id <= '0;
            j_cnt    <= '0;
            acc      <= '0;
            best     <= 20'h80000;
            w_base   <= '0;
            pend     <= 1'b0;
        end else begin
            pend <= crd;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        j_cnt    <= '0;
                        acc      <= '0;
                        best     <= 20'h80000;
                        class_id <= '0;
                        w_base   <= '0;
                        crd      <= 1'b1;
                        wrd      <= 1'b1;
                        csel     <= CSEL_RD;
                        caddr_rd <= '0;
                        waddr    <= '0;
                    end
                end
                S_FETCH: begin
                    if (pend) begin
                        acc <= acc + {{8{prod[39]}}, prod};
                    end
                    if (caddr_rd == I_LAST) begin
                        state <= S_TAIL;
                        crd   <= 1'b0;
                        waddr <= BIAS_BASE + WADDR_W'(j_cnt);
                    end else begin
                        caddr_rd <= caddr_rd + 12'd1;
                        waddr    <= waddr + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (pend) begin
                        acc <= acc + {{8{prod[39]}}, prod};
                    end
                    state <= S_BIAS;
                    wrd   <= 1'b0;
                end
                S_BIAS: begin
                    state    <= S_WRITE;
                    cwr      <= 1'b1;
                    csel     <= CSEL_WR;
                    caddr_wr <= {8'b0, j_cnt};
                    cdata_wr <= s_res;
                end
                S_WRITE: begin
                    cwr <= 1'b0;
                    if ($signed(cdata_wr) > $signed(best)) begin
                        best     <= cdata_wr;
                        class_id <= j_cnt;
                    end
                    if (j_cnt != J_LAST) begin
                        state    <= S_FETCH;
                        j_cnt    <= j_cnt + 4'd1;
                        acc      <= '0;
                        w_base   <= w_base + ROW_STEP;
                        crd      <= 1'b1;
                        wrd      <= 1'b1;
                        csel     <= CSEL_RD;
                        caddr_rd <= '0;
                        waddr    <= w_base + ROW_STEP;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classify.sv
// tb_fc_classify: directed and random runs of fc_classify (RELU=1 and RELU=0
// instances side by side), checked against a plain-arithmetic dot-product model.
module tb_fc_classify;

    localparam int N_IN    = 16;
    localparam int N_OUT   = 10;
    localparam int WADDR_W = 8;
    localparam int LAT     = N_OUT * (N_IN + 3) + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic busy_r, done_r, crd_r, cwr_r, wrd_r;
    logic [11:0] caddr_rd_r, caddr_wr_r;
    logic [19:0] cdata_rd_r = '0, wdata_r = '0, cdata_wr_r;
    logic [2:0] csel_r;
    logic [WADDR_W-1:0] waddr_r;
    logic [3:0] class_id_r;

    logic busy_l, done_l, crd_l, cwr_l, wrd_l;
    logic [11:0] caddr_rd_l, caddr_wr_l;
    logic [19:0] cdata_rd_l = '0, wdata_l = '0, cdata_wr_l;
    logic [2:0] csel_l;
    logic [WADDR_W-1:0] waddr_l;
    logic [3:0] class_id_l;

    fc_classify #(.N_IN(N_IN), .N_OUT(N_OUT), .WADDR_W(WADDR_W), .RELU(1)) u_relu (
        .clk(clk), .reset(reset), .start(start), .busy(busy_r), .done(done_r),
        .crd(crd_r), .caddr_rd(caddr_rd_r), .cdata_rd(cdata_rd_r), .csel(csel_r),
        .cwr(cwr_r), .caddr_wr(caddr_wr_r), .cdata_wr(cdata_wr_r), .wrd(wrd_r),
        .waddr(waddr_r), .wdata(wdata_r), .class_id(class_id_r)
    );

    fc_classify #(.N_IN(N_IN), .N_OUT(N_OUT), .WADDR_W(WADDR_W), .RELU(0)) u_lin (
        .clk(clk), .reset(reset), .start(start), .busy(busy_l), .done(done_l),
        .crd(crd_l), .caddr_rd(caddr_rd_l), .cdata_rd(cdata_rd_l), .csel(csel_l),
        .cwr(cwr_l), .caddr_wr(caddr_wr_l), .cdata_wr(cdata_wr_l), .wrd(wrd_l),
        .waddr(waddr_l), .wdata(wdata_l), .class_id(class_id_l)
    );

    logic [19:0] in_mem [N_IN];
    logic [19:0] w_mem  [256];

    // Memories answer one cycle after a registered read request.
    always @(posedge clk) begin
        if (crd_r) cdata_rd_r <= in_mem[caddr_rd_r[3:0]];
        if (wrd_r) wdata_r    <= w_mem[waddr_r];
        if (crd_l) cdata_rd_l <= in_mem[caddr_rd_l[3:0]];
        if (wrd_l) wdata_l    <= w_mem[waddr_l];
    end

    logic [19:0] res_r [16];
    logic [19:0] res_l [16];
    int wtot_r = 0, wtot_l = 0, perr = 0;

    always @(negedge clk) begin
        if (cwr_r) begin
            res_r[caddr_wr_r[3:0]] = cdata_wr_r;
            wtot_r++;
            if (csel_r !== 3'b110 || crd_r || wrd_r) perr++;
        end
        if (cwr_l) begin
            res_l[caddr_wr_l[3:0]] = cdata_wr_l;
            wtot_l++;
            if (csel_l !== 3'b110 || crd_l || wrd_l) perr++;
        end
        if (crd_r && csel_r !== 3'b101) perr++;
        if ((crd_r || wrd_r || cwr_r) && !busy_r) perr++;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product, round half up, bias, clamp, ReLU.
    function automatic logic [19:0] ref_neuron(input int j, input bit relu);
        longint acc, r, s;
        acc = 0;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(in_mem[i])) * longint'($signed(w_mem[j*N_IN+i]));
        r = (acc >>> 16) + ((acc >>> 15) & 64'sd1);
        s = r + longint'($signed(w_mem[N_OUT*N_IN+j]));
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
        if (relu && s < 0) s = 0;
        return s[19:0];
    endfunction

    logic [19:0] exp_r [N_OUT];
    logic [19:0] exp_l [N_OUT];
    int exp_cls_r, exp_cls_l;

    task automatic compute_expected();
        int best_r, best_l, v;
        best_r = -2000000; best_l = -2000000;
        exp_cls_r = 0; exp_cls_l = 0;
        for (int j = 0; j < N_OUT; j++) begin
            exp_r[j] = ref_neuron(j, 1'b1);
            exp_l[j] = ref_neuron(j, 1'b0);
            v = $signed(exp_r[j]);
            if (v > best_r) begin best_r = v; exp_cls_r = j; end
            v = $signed(exp_l[j]);
            if (v > best_l) begin best_l = v; exp_cls_l = j; end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N_IN; i++) in_mem[i] = '0;
        for (int i = 0; i < 256; i++) w_mem[i] = '0;
    endtask

    function automatic logic [19:0] rnd(input int span);
        return 20'($urandom_range(0, 2*span - 1)) - 20'(span);
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_check(input string name, input bit mid);
        int cyc, wr0, wl0;
        bit got;
        compute_expected();
        wr0 = wtot_r; wl0 = wtot_l;
        pulse_start();
        check({name, " busy_after_start"}, busy_r, 1);
        check({name, " first_issue"}, {crd_r, wrd_r, csel_r, caddr_rd_r, waddr_r},
              {1'b1, 1'b1, 3'b101, 12'd0, 8'd0});
        cyc = 0; got = 0;
        while (cyc < 1000 && !got) begin
            if (mid && cyc == 50) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
            if (done_r) got = 1;
        end
        check({name, " done_seen"}, got, 1);
        check({name, " latency"}, cyc + 1, LAT);
        check({name, " done_lin"}, done_l, 1);
        check({name, " busy_at_done"}, busy_r, 1);
        check({name, " writes_r"}, wtot_r - wr0, N_OUT);
        check({name, " writes_l"}, wtot_l - wl0, N_OUT);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s res_r[%0d]", name, j), res_r[j], exp_r[j]);
            check($sformatf("%s res_l[%0d]", name, j), res_l[j], exp_l[j]);
        end
        check({name, " class_r"}, class_id_r, exp_cls_r);
        check({name, " class_l"}, class_id_l, exp_cls_l);
        @(posedge clk);
        #1;
        check({name, " idle_after"}, {busy_r, done_r, busy_l, done_l}, 4'b0);
        check({name, " class_held"}, class_id_r, exp_cls_r);
        check({name, " protocol"}, perr, 0);
    endtask

    initial begin
        int cyc;
        clear_mem();
        #2 reset = 1'b0;
        #10;
        check("reset_ctrl", {busy_r, done_r, crd_r, wrd_r, cwr_r, csel_r}, 8'b0);
        check("reset_data", {caddr_rd_r, caddr_wr_r, cdata_wr_r, waddr_r, class_id_r}, 56'b0);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {busy_r, crd_r, csel_r}, 5'b0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_no_start", {busy_r, crd_r, wrd_r, cwr_r}, 4'b0);

        // Zero data, bias j*0x01000.
        for (int j = 0; j < N_OUT; j++) w_mem[N_OUT*N_IN+j] = 20'(j * 4096);
        run_check("bias_only", 1'b0);
        check("bias_only res9", res_r[9], 20'h09000);
        check("bias_only class9", class_id_r, 4'd9);

        // in[0]=1.0, w[j][0]=0.5 for all j: ties resolve to index 0.
        clear_mem();
        in_mem[0] = 20'h10000;
        for (int j = 0; j < N_OUT; j++) w_mem[j*N_IN] = 20'h08000;
        run_check("tie", 1'b0);
        check("tie res5", res_r[5], 20'h08000);
        check("tie class0", class_id_r, 4'd0);

        // Negative neuron 3: ReLU clamps, linear keeps -1.0.
        clear_mem();
        in_mem[5] = 20'h10000;
        w_mem[3*N_IN+5] = 20'hF0000;
        run_check("neg", 1'b0);
        check("neg relu3", res_r[3], 20'h00000);
        check("neg lin3", res_l[3], 20'hF0000);

        // Positive and negative saturation.
        clear_mem();
        for (int i = 0; i < N_IN; i++) in_mem[i] = 20'h70000;
        for (int i = 0; i < N_OUT*N_IN; i++) w_mem[i] = 20'h70000;
        run_check("sat_pos", 1'b0);
        check("sat_pos res0", res_r[0], 20'h7FFFF);
        for (int i = 0; i < N_OUT*N_IN; i++) w_mem[i] = 20'h90000;
        run_check("sat_neg", 1'b0);
        check("sat_neg lin0", res_l[0], 20'h80000);
        check("sat_neg relu0", res_r[0], 20'h00000);

        // Random data, one run with an ignored mid-run start.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N_IN; i++) in_mem[i] = rnd(131072);
            for (int i = 0; i < N_OUT*N_IN; i++) w_mem[i] = rnd(16384);
            for (int j = 0; j < N_OUT; j++) w_mem[N_OUT*N_IN+j] = rnd(65536);
            run_check($sformatf("rand%0d", k), k == 1);
        end

        // Reset during neuron 4 FETCH, then a full run.
        compute_expected();
        begin
            int wr0;
            wr0 = wtot_r;
            pulse_start();
            cyc = 0;
            while (cyc < 4*(N_IN+3) + 5) begin
                @(posedge clk);
                #1 cyc++;
            end
            reset = 1'b0;
            #1;
            check("abort_ctrl", {busy_r, done_r, crd_r, wrd_r, cwr_r, csel_r}, 8'b0);
            check("abort_data", {caddr_rd_r, caddr_wr_r, cdata_wr_r, waddr_r, class_id_r}, 56'b0);
            check("abort_writes", wtot_r - wr0, 4);
            for (int j = 0; j < 4; j++)
                check($sformatf("abort res_r[%0d]", j), res_r[j], exp_r[j]);
        end
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("abort_quiet", {busy_r, cwr_r, crd_r}, 3'b0);
        for (int i = 0; i < N_IN; i++) in_mem[i] = rnd(131072);
        run_check("after_abort", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
